// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: two-stage pipelined carry-lookahead adder with valid/ready handshakes
module cla_pipe_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryInput,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryOutput,
  output logic             prop,
  output logic             gene,
  output logic             overflow
);
  localparam int NGRP = WIDTH / 4;

  logic [WIDTH-1:0] bp, bg, p1, g1;
  logic [NGRP-1:0]  gp, gg, gp1, gg1;
  logic             cin1, v1, v2, ready1;
  logic [NGRP:0]    ge, nc;
  logic [WIDTH:0]   c;
  logic             wg, t1, t2;

  assign bp = a ^ b;
  assign bg = a & b;

  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    assign gp[k] = &bp[4*k +: 4];
    assign gg[k] = bg[4*k+3] | (bp[4*k+3] & bg[4*k+2]) | (&bp[4*k+2 +: 2] & bg[4*k+1]) | (&bp[4*k+1 +: 3] & bg[4*k]);
  end

  assign ready1    = !v2 | out_ready;
  assign in_ready  = !v1 | ready1;
  assign out_valid = v2;

  // stage 1: capture bit and group propagate/generate terms on accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {v1, p1, g1, gp1, gg1, cin1} <= '0;
    end else if (in_ready) begin
      v1 <= in_valid;
      if (in_valid) begin
        p1   <= bp;
        g1   <= bg;
        gp1  <= gp;
        gg1  <= gg;
        cin1 <= carryInput;
      end
    end
  end

  // second-level lookahead: nibble carry-ins from group terms, plus word generate
  always_comb begin
    ge = {gg1, cin1};
    nc = '0;
    wg = 1'b0;
    t1 = 1'b0;
    for (int k = 0; k <= NGRP; k++) begin
      for (int j = 0; j <= k; j++) begin
        t1 = ge[j];
        for (int m = j; m < k; m++) t1 = t1 & gp1[m];
        nc[k] = nc[k] | t1;
        if (k == NGRP && j > 0) wg = wg | t1;
      end
    end
  end

  // in-nibble lookahead: bit carries from each nibble carry-in
  always_comb begin
    c = '0;
    t2 = 1'b0;
    for (int k = 0; k < NGRP; k++) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j <= i; j++) begin
          t2 = (j == 0) ? nc[k] : g1[4*k+j-1];
          for (int m = j; m < i; m++) t2 = t2 & p1[4*k+m];
          c[4*k+i] = c[4*k+i] | t2;
        end
      end
    end
    c[WIDTH] = nc[NGRP];
  end

  // stage 2: register the finished result and flags when the output slot is free
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {v2, sum, carryOutput, prop, gene, overflow} <= '0;
    end else if (ready1) begin
      v2 <= v1;
      if (v1) begin
        sum         <= p1 ^ c[WIDTH-1:0];
        carryOutput <= c[WIDTH];
        prop        <= &p1;
        gene        <= wg;
        overflow    <= c[WIDTH-1] ^ c[WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed self-checking bench for cla_pipe_adder
module tb_cla_pipe_adder;
  logic        clk = 0, rst = 0, in_valid = 0, in_ready, carryInput = 0;
  logic        out_valid, out_ready = 1, carryOutput, prop, gene, overflow;
  logic [15:0] a = 0, b = 0, sum;
  logic [20:0] obs;
  int          n_cmp = 0, n_bad = 0;

  cla_pipe_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carryInput(carryInput), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .carryOutput(carryOutput),
    .prop(prop), .gene(gene), .overflow(overflow)
  );

  always #5 clk = ~clk;
  // {out_valid, sum, carryOutput, prop, gene, overflow}
  assign obs = {out_valid, sum, carryOutput, prop, gene, overflow};

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (obs !== 21'h0) begin n_bad++; $display("FAIL reset_outputs got=%h want=%h", obs, 21'h0); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
    rst = 1;
    step();
  endtask

  task automatic test_arith();
    logic [15:0] va [5] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'hAAAA, 16'h1234};
    logic [15:0] vb [5] = '{16'h0001, 16'h0001, 16'h8000, 16'h5555, 16'h4321};
    logic        vc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [20:0] ex [5] = '{{1'b1, 16'h0000, 4'b1010}, {1'b1, 16'h8000, 4'b0001},
                            {1'b1, 16'h0000, 4'b1011}, {1'b1, 16'h0000, 4'b1100},
                            {1'b1, 16'h5556, 4'b0000}};
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      a = va[i]; b = vb[i]; carryInput = vc[i]; in_valid = 1;
      step();
      in_valid = 0; a = 16'hDEAD; b = 16'hBEEF; carryInput = 1;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arith%0d_early_valid got=%b want=0", i, out_valid); end
      step();
      n_cmp++;
      if (obs !== ex[i]) begin n_bad++; $display("FAIL arith%0d_result got=%h want=%h", i, obs, ex[i]); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [3] = '{16'd1, 16'd3, 16'd5};
    logic [15:0] vb [3] = '{16'd2, 16'd4, 16'd6};
    logic [15:0] es [3] = '{16'd3, 16'd7, 16'd11};
    out_ready = 1; carryInput = 0;
    for (int k = 0; k < 5; k++) begin
      if (k >= 2) begin
        n_cmp++;
        if (obs !== {1'b1, es[k-2], 4'b0000}) begin n_bad++; $display("FAIL b2b_result%0d got=%h want=%h", k - 2, obs, {1'b1, es[k-2], 4'b0000}); end
      end
      if (k < 3) begin
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready%0d got=%b want=1", k, in_ready); end
        a = va[k]; b = vb[k]; in_valid = 1;
      end else in_valid = 0;
      step();
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drained got=%b want=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 0; carryInput = 0;
    a = 16'd10; b = 16'd20; in_valid = 1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready0 got=%b want=1", in_ready); end
    step();
    a = 16'd30; b = 16'd40;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready1 got=%b want=1", in_ready); end
    step();
    a = 16'd50; b = 16'd60;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_stall_ready%0d got=%b want=0", k, in_ready); end
      n_cmp++;
      if (obs !== {1'b1, 16'd30, 4'b0000}) begin n_bad++; $display("FAIL bp_hold%0d got=%h want=%h", k, obs, {1'b1, 16'd30, 4'b0000}); end
      if (k < 4) step();
    end
    out_ready = 1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
    step();
    in_valid = 0;
    n_cmp++;
    if (obs !== {1'b1, 16'd70, 4'b0000}) begin n_bad++; $display("FAIL bp_drain1 got=%h want=%h", obs, {1'b1, 16'd70, 4'b0000}); end
    step();
    n_cmp++;
    if (obs !== {1'b1, 16'd110, 4'b0000}) begin n_bad++; $display("FAIL bp_drain2 got=%h want=%h", obs, {1'b1, 16'd110, 4'b0000}); end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 0; carryInput = 1;
    a = 16'h1111; b = 16'h2222; in_valid = 1;
    step();
    a = 16'h3333; b = 16'h4444;
    step();
    in_valid = 0;
    n_cmp++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rm_pre_valid got=%b want=1", out_valid); end
    #2 rst = 0;
    #1;
    n_cmp++;
    if (obs !== 21'h0) begin n_bad++; $display("FAIL rm_async_clear got=%h want=%h", obs, 21'h0); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rm_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
    rst = 1; out_ready = 1; carryInput = 0;
    a = 16'h0010; b = 16'h0020; in_valid = 1;
    step();
    in_valid = 0;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rm_early_valid got=%b want=0", out_valid); end
    step();
    n_cmp++;
    if (obs !== {1'b1, 16'h0030, 4'b0000}) begin n_bad++; $display("FAIL rm_fresh got=%h want=%h", obs, {1'b1, 16'h0030, 4'b0000}); end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rm_no_ghost got=%b want=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
